// File: rtl/seq_mul_pkg.sv
// Shared types and sizing constants for the sequential shift-and-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int W_DEFAULT = 8;
  localparam int P_W       = 2 * W_DEFAULT;

endpackage

// File: rtl/seq_shift_add_mul_if.sv
// Operand/result valid-ready bundle for the sequential multiplier.
// master drives operands and consumes the product; slave is the multiplier.
import seq_mul_pkg::*;

interface seq_shift_add_mul_if #(parameter int W = W_DEFAULT);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   o;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, o
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, o
  );

endinterface

// File: rtl/cla_adder16.sv
// Combinational 16-bit carry-lookahead adder: four 4-bit lookahead groups
// whose group generate/propagate feed a second lookahead level.
module cla_adder16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] sum
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [3:0]  gc;

  assign g = x & y;
  assign p = x ^ y;

  // Group generate and propagate for each 4-bit slice
  always_comb begin
    gg = '0;
    pg = '0;
    for (int k = 0; k < 4; k++) begin
      int bs;
      bs = 4 * k;
      gg[k] = g[bs+3] | (p[bs+3] & g[bs+2]) | (p[bs+3] & p[bs+2] & g[bs+1]) |
              (p[bs+3] & p[bs+2] & p[bs+1] & g[bs]);
      pg[k] = &p[bs +: 4];
    end
  end

  // Second-level lookahead: carry into each group straight from cin
  always_comb begin
    gc    = '0;
    gc[0] = cin;
    gc[1] = gg[0] | (pg[0] & cin);
    gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) |
            (pg[2] & pg[1] & pg[0] & cin);
  end

  // In-group lookahead carries from each group's carry-in
  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      int bs;
      bs = 4 * k;
      c[bs]   = gc[k];
      c[bs+1] = g[bs] | (p[bs] & gc[k]);
      c[bs+2] = g[bs+1] | (p[bs+1] & g[bs]) | (p[bs+1] & p[bs] & gc[k]);
      c[bs+3] = g[bs+2] | (p[bs+2] & g[bs+1]) | (p[bs+2] & p[bs+1] & g[bs]) |
                (p[bs+2] & p[bs+1] & p[bs] & gc[k]);
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/seq_shift_add_mul.sv
// Sequential unsigned W x W -> 2W multiplier using shift-and-add through a
// 16-bit carry-lookahead adder, with valid/ready on operands and product.
// Optional macro SEQ_MUL_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all zero (and skip RUN entirely when b is zero).
module seq_shift_add_mul
  import seq_mul_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  seq_shift_add_mul_if.slave bus
);

  localparam int P  = 2 * W;
  localparam int CW = $clog2(W) + 1;

  state_t         state;
  state_t         next_state;
  logic [P-1:0]   acc;
  logic [P-1:0]   mcand;
  logic [P-1:0]   prod;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic [15:0]    add_x;
  logic [15:0]    add_y;
  logic [15:0]    add_sum;
  logic [P-1:0]   acc_next;
  logic           last_iter;
  logic           zero_b;
  logic           in_ready;
  logic           out_valid;

  // The adder sees the running accumulator and the shifted multiplicand
  assign add_x = 16'(acc);
  assign add_y = 16'(mcand);

  cla_adder16 u_adder (
    .x   (add_x),
    .y   (add_y),
    .cin (1'b0),
    .sum (add_sum)
  );

  assign acc_next = mplier[0] ? P'(add_sum) : acc;

`ifdef SEQ_MUL_EARLY_TERM_EN
  assign last_iter = (cnt == CW'(W - 1)) || ((mplier >> 1) == '0);
  assign zero_b    = (bus.b == '0);
`else
  assign last_iter = (cnt == CW'(W - 1));
  assign zero_b    = 1'b0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.o         = prod;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs derived from the current state
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          next_state = zero_b ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: load operands on accept, shift/accumulate in RUN, latch product on the last step
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      prod   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand  <= P'(bus.a);
            mplier <= bus.b;
            acc    <= '0;
            cnt    <= '0;
            if (zero_b) begin
              prod <= '0;
            end
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last_iter) begin
            prod <= acc_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Self-checking bench for seq_shift_add_mul: vector table, hand-written
// multi-cycle sequences, and a random sweep against a behavioural model.
module tb_seq_shift_add_mul;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   errors;
  int   ops_done;
  int   hs_count;

  seq_shift_add_mul_if #(.W(W)) bus ();

  seq_shift_add_mul #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every product handshake seen on the result side
  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      hs_count <= hs_count + 1;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Cycles from the accept cycle until out_valid is first seen
  function automatic int exp_latency(input logic [W-1:0] bv);
    int hi;
    hi = 0;
    for (int i = 0; i < W; i++) begin
      if (bv[i]) hi = i + 1;
    end
`ifdef SEQ_MUL_EARLY_TERM_EN
    if (bv == 0) return 1;
    return 1 + ((hi > 1) ? hi : 1);
`else
    return W + 1;
`endif
  endfunction

  // Present operands, wait for accept, then wait for the product
  task automatic accept_and_wait(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 output int lat);
    int guard;
    int busy_ready;
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    guard = 0;
    while (!bus.in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check_output("accept_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    busy_ready = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) busy_ready++;
      @(negedge clk);
      lat++;
    end
    check_output("in_ready_while_busy", busy_ready, 0);
  endtask

  // Full transaction with a number of out_ready stall cycles in DONE
  task automatic apply_stimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                input int stall, output logic [2*W-1:0] res,
                                output int lat);
    int unstable;
    accept_and_wait(av, bv, lat);
    res = bus.o;
    unstable = 0;
    for (int s = 0; s < stall; s++) begin
      if (!bus.out_valid || bus.o !== res) unstable++;
      @(negedge clk);
    end
    check_output("done_hold", unstable, 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    ops_done++;
    check_output("idle_after_handshake", int'({bus.out_valid, bus.in_ready}), 1);
  endtask

  vec_t vecs[8];

  initial begin
    logic [2*W-1:0] res;
    int             lat;
    int             guard;
    int             seen;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;

    tests    = 0;
    errors   = 0;
    ops_done = 0;
    hs_count = 0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{8'd13, 8'd11, 16'h008F};
    vecs[2] = '{8'h00, 8'h5A, 16'h0000};
    vecs[3] = '{8'h80, 8'h02, 16'h0100};
    vecs[4] = '{8'h55, 8'h01, 16'h0055};
    vecs[5] = '{8'hFF, 8'h00, 16'h0000};
    vecs[6] = '{8'h02, 8'h03, 16'h0006};
    vecs[7] = '{8'h01, 8'h80, 16'h0080};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_output("reset_in_ready", int'(bus.in_ready), 1);
    check_output("reset_out_valid", int'(bus.out_valid), 0);
    check_output("reset_o", int'(bus.o), 0);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].b, i % 3, res, lat);
      check_output($sformatf("vec%0d_o", i), int'(res), int'(vecs[i].prod));
      check_output($sformatf("vec%0d_latency", i), lat, exp_latency(vecs[i].b));
    end

    // Back-to-back operands with in_valid held high
    bus.a = 8'd13;
    bus.b = 8'd11;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    bus.a = 8'h00;
    bus.b = 8'h5A;
    bus.out_ready = 1'b1;
    guard = 0;
    while (!bus.out_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check_output("b2b_first_o", int'(bus.o), 16'h008F);
    @(negedge clk);
    ops_done++;
    check_output("b2b_idle_gap", int'({bus.out_valid, bus.in_ready}), 1);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_output("b2b_second_accepted", int'(bus.in_ready), 0);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_output("b2b_second_o", int'(bus.o), 0);
    check_output("b2b_second_latency", lat, exp_latency(8'h5A));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    ops_done++;

    // Long stall in DONE with in_valid pulses that must be ignored
    accept_and_wait(8'h80, 8'h02, lat);
    seen = 0;
    for (int s = 0; s < 5; s++) begin
      if (!bus.out_valid || bus.o !== 16'h0100 || bus.in_ready) seen++;
      bus.a = 8'hAA;
      bus.b = 8'h77;
      bus.in_valid = (s % 2 == 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check_output("stall_hold", seen, 0);
    check_output("stall_o", int'(bus.o), 16'h0100);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    ops_done++;
    @(negedge clk);
    check_output("stall_no_extra_op", int'({bus.out_valid, bus.in_ready}), 1);

    // Reset in the middle of RUN discards the operation
    bus.a = 8'h37;
    bus.b = 8'hC3;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_output("mid_run_busy", int'(bus.in_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("mid_reset_in_ready", int'(bus.in_ready), 1);
    check_output("mid_reset_out_valid", int'(bus.out_valid), 0);
    check_output("mid_reset_o", int'(bus.o), 0);
    seen = 0;
    for (int s = 0; s < 12; s++) begin
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    check_output("mid_reset_no_result", seen, 0);
    apply_stimulus(8'h02, 8'h03, 0, res, lat);
    check_output("post_reset_o", int'(res), 16'h0006);

    // Random sweep against plain multiplication
    seen = 0;
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 17 == 0) rb = '0;
      if (n % 13 == 0) ra = '0;
      apply_stimulus(ra, rb, int'($urandom_range(0, 3)), res, lat);
      if (res !== 16'(ra * rb) || lat != exp_latency(rb)) begin
        seen++;
        if (seen <= 5) begin
          $display("[TB] FAIL rand_op: a=0x%0h b=0x%0h got 0x%0h lat %0d, expected 0x%0h lat %0d",
                   ra, rb, res, lat, 16'(ra * rb), exp_latency(rb));
        end
      end
    end
    check_output("random_sweep_errors", seen, 0);

    @(negedge clk);
    check_output("handshake_count", hs_count, ops_done);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
